fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Drain stage directly downstream of the block-RAM byte FIFO.
- Pops one word at a time whenever the FIFO is non-empty and enable is high.
- Serialises each word onto an asynchronous 8N1/8N2-style line at a parameterised bit period.
- Sits between the host-side FIFO and the external tx pin of the debug/telemetry UART.

Parameters:
- DATA_WIDTH, 8, bits per frame payload; must match the upstream FIFO word width.
- CLKS_PER_BIT, 434, clock cycles per serial bit; legal range 2..65535.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  in  1  upstream FIFO empty flag.
- fifo_data  in  DATA_WIDTH  upstream FIFO head word (synchronous-RAM output).
- fifo_read  out  1  one-cycle pop strobe to the upstream FIFO.
- tx  out  1  serial line; idle high.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Interface fixed: single clock clk; reset is asynchronous and active-high.
- Reset values:
  - tx=1, fifo_read=0, busy=0, frame_done=0.
  - state=IDLE; bit counter and shift register cleared.
- Reset assertion mid-frame forces tx=1 immediately, with no clock needed. A word already popped is discarded, not re-sent.
- All outputs are registered or decoded directly from registered state. No combinational path from any input to any output.
- State machine: IDLE -> LOAD -> START -> DATA -> STOP -> IDLE.
- IDLE:
  - tx=1.
  - If enable=1 and fifo_empty=0, go to LOAD next cycle.
- LOAD: exactly one cycle.
  - fifo_read=1; latch fifo_data into the shift register at the end of this cycle.
  - The one-cycle IDLE->LOAD gap is mandatory. It guarantees the synchronous-RAM output reflects the head address, including a word written only one cycle before empty deasserted.
  - Go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - Go to DATA with bit index 0.
- DATA:
  - tx = shift register bit 0, LSB first, held CLKS_PER_BIT cycles per bit.
  - Shift right after each bit.
  - After bit DATA_WIDTH-1, go to STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle; then go to IDLE.
- Back-to-back frames: one IDLE cycle plus one LOAD cycle between the stop bit end and the next start bit. Inter-frame idle is exactly 2 cycles.
- enable:
  - Deassertion mid-frame does not abort; the current frame completes.
  - No new pop occurs while enable=0.
- fifo_read:
  - Asserted only in LOAD, and LOAD is entered only when fifo_empty=0. Never pops an empty FIFO.
  - Never asserted on consecutive cycles.
- Bit-period counter:
  - Width $clog2(CLKS_PER_BIT*STOP_BITS); counts 0..limit-1 and wraps to 0 on state or bit advance.
  - No off-by-one: every bit is exactly CLKS_PER_BIT cycles.
- Bit index: width $clog2(DATA_WIDTH)+1; no wrap is relied upon.
- Frame latency: the first falling tx edge occurs 2 cycles after fifo_empty is first seen low in IDLE with enable=1.

Decomposition:
- Shared package uart_pkg:
  - State encoding localparams IDLE/LOAD/START/DATA/STOP, 3-bit.
  - Function for counter width.
- One sub-module is natural: uart_bit_timer.
  - Loadable down-counter with a terminal-count pulse.
  - Reused later by the matching receiver.

Test Plan:
- Basic frame: reset, write 0xA5 to FIFO, enable=1, CLKS_PER_BIT=4.
  - Exactly one fifo_read pulse.
  - tx sequence of 4-cycle bits: 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop).
  - frame_done 40 cycles after start edge; busy low afterwards.
- Burst: FIFO preloaded 0x00,0xFF,0x55 with enable held.
  - Three frames, each with a 2-cycle idle gap.
  - Three fifo_read pulses; data order preserved.
  - FIFO empty=1 after the third pop; no fourth pop.
- Write-then-drain race: write 0x3C to an empty FIFO on the same cycle the block is IDLE.
  - Serialised byte is 0x3C, not stale RAM contents.
- Enable gating: deassert enable mid-DATA of frame 1 with 2 bytes queued.
  - Frame 1 completes; no further fifo_read until enable returns high.
  - Frame 2 then starts 2 cycles later.
- Async reset mid-frame: assert reset during bit 3.
  - tx=1 with no clock edge; state IDLE.
  - After release with FIFO non-empty, the next queued byte is sent intact.
- STOP_BITS=2, CLKS_PER_BIT=2: send 0x81.
  - Stop phase is 4 cycles high; frame_done on the 4th cycle.
  - Total frame length 22 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and bit-timer sizing.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } uart_state_t;

    // The bit timer must hold the longest phase minus one (the stop phase
    // when two stop bits are used); never narrower than one bit.
    function automatic int cnt_width(input int clks_per_bit, input int stop_bits);
        int span;
        span = clks_per_bit * stop_bits;
        return (span > 1) ? $clog2(span) : 1;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter marking the last cycle of a bit/phase period.
// Latency: done is decoded from the count register; load takes effect next cycle.
// Backpressure: none; holds at zero until reloaded.
module uart_bit_timer #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count_q;

    // Load a period-minus-one value, then count down and park at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a sync-RAM byte FIFO one word at a time and serialises it as 8N1/8N2.
// Latency: first start-bit edge 2 cycles after a non-empty FIFO is seen in IDLE with enable high.
// Backpressure: pops only from IDLE via a one-cycle LOAD; never pops empty, never pops twice in a row.
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT, STOP_BITS);
    localparam int IDX_W = $clog2(DATA_WIDTH) + 1;

    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LOAD = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);

    uart_state_t           state_q;
    uart_state_t           state_d;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [IDX_W-1:0]      bit_idx_q;
    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_val;
    logic                  tmr_done;

    uart_bit_timer #(
        .WIDTH (CNT_W)
    ) u_bit_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // State register; reset drops straight to IDLE so tx returns high without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and timer reload: every phase reloads on entry so each bit is exactly one period.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = BIT_LOAD;
        case (state_q)
            IDLE: begin
                // LOAD gap gives the sync RAM one cycle to present the head word.
                if (enable && !fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d  = START;
                tmr_load = 1'b1;
            end
            START: begin
                if (tmr_done) begin
                    state_d  = DATA;
                    tmr_load = 1'b1;
                end
            end
            DATA: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                        tmr_val = STOP_LOAD;
                    end
                end
            end
            STOP: begin
                if (tmr_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the popped word in LOAD, then shift LSB-first at each data bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else if (state_q == LOAD) begin
            shift_q   <= fifo_data;
            bit_idx_q <= '0;
        end else if ((state_q == DATA) && tmr_done) begin
            shift_q   <= shift_q >> 1;
            bit_idx_q <= bit_idx_q + IDX_W'(1);
        end
    end

    // Outputs decoded from registered state only; no input reaches an output combinationally.
    always_comb begin
        fifo_read  = (state_q == LOAD);
        busy       = (state_q != IDLE);
        frame_done = (state_q == STOP) && tmr_done;
        tx         = 1'b1;
        if (state_q == START) begin
            tx = 1'b0;
        end else if (state_q == DATA) begin
            tx = shift_q[0];
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench: two configurations (4 clk/bit 1 stop, 2 clk/bit 2 stop) fed from a sync-RAM FIFO model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fifo_uart_tx;

    localparam int DW = 8;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] reset;
    logic [1:0] enable;
    logic [1:0] fifo_empty;
    logic [1:0] fifo_read;
    logic [1:0] tx;
    logic [1:0] busy;
    logic [1:0] frame_done;
    logic [7:0] fifo_data [2];

    logic [1:0] push_vld;
    logic [7:0] push_dat [2];
    logic [7:0] mem [2][16];
    logic [4:0] wr [2];
    logic [4:0] rd [2];

    int         cyc;
    int         n_chk;
    int         n_bad;
    bit         m_act [2];
    int         m_pos [2];
    int         pop_cnt [2];
    int         frame_cnt [2];
    int         push_cnt [2];
    int         last_start [2];
    int         last_done [2];
    logic       prev_read [2];
    logic [7:0] inflight [2];
    logic [7:0] sent_q [$];
    int         st_log [$];
    int         dn_log [$];

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .reset(reset[0]), .enable(enable[0]), .fifo_empty(fifo_empty[0]),
        .fifo_data(fifo_data[0]), .fifo_read(fifo_read[0]), .tx(tx[0]), .busy(busy[0]),
        .frame_done(frame_done[0])
    );

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(2), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .reset(reset[1]), .enable(enable[1]), .fifo_empty(fifo_empty[1]),
        .fifo_data(fifo_data[1]), .fifo_read(fifo_read[1]), .tx(tx[1]), .busy(busy[1]),
        .frame_done(frame_done[1])
    );

    function automatic int cpb_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic int sb_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    assign fifo_empty[0] = (wr[0] == rd[0]);
    assign fifo_empty[1] = (wr[1] == rd[1]);

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream FIFO: registered RAM read of the head address, so a fresh write shows a cycle late.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset[0] && reset[1]) begin
                wr[i]        <= '0;
                rd[i]        <= '0;
                fifo_data[i] <= 8'hC3;
                for (int k = 0; k < 16; k++) mem[i][k] <= 8'hC3;
            end else begin
                if (push_vld[i]) begin
                    mem[i][wr[i][3:0]] <= push_dat[i];
                    wr[i]              <= wr[i] + 5'd1;
                end
                if (fifo_read[i] === 1'b1) rd[i] <= rd[i] + 5'd1;
                fifo_data[i] <= mem[i][rd[i][3:0]];
            end
        end
    end

    // Line monitor: expected waveform of each frame is start, LSB-first data, stop, each bit cpb cycles.
    always @(negedge clk) begin : mon
        int   flen;
        int   b;
        logic exp_tx;
        for (int i = 0; i < 2; i++) begin
            if (reset[i] !== 1'b0) begin
                m_act[i]     = 1'b0;
                prev_read[i] = 1'b0;
            end else begin
                if (fifo_read[i] === 1'b1) begin
                    chk("pop_in_frame", 32'(m_act[i]), 32'd0);
                    chk("pop_b2b", 32'(prev_read[i]), 32'd0);
                    chk("pop_empty", 32'(fifo_empty[i]), 32'd0);
                    inflight[i] = mem[i][rd[i][3:0]];
                    pop_cnt[i]++;
                end
                prev_read[i] = fifo_read[i];
                if (!m_act[i]) begin
                    if (tx[i] === 1'b0) begin
                        m_act[i]      = 1'b1;
                        m_pos[i]      = 0;
                        last_start[i] = cyc;
                        if (i == 0) st_log.push_back(cyc);
                    end else begin
                        chk("done_idle", 32'(frame_done[i]), 32'd0);
                    end
                end
                if (m_act[i]) begin
                    flen = (1 + DW + sb_of(i)) * cpb_of(i);
                    b    = m_pos[i] / cpb_of(i);
                    if (b == 0)       exp_tx = 1'b0;
                    else if (b <= DW) exp_tx = inflight[i][b-1];
                    else              exp_tx = 1'b1;
                    chk("tx", 32'(tx[i]), 32'(exp_tx));
                    chk("frame_done", 32'(frame_done[i]), 32'(m_pos[i] == flen - 1));
                    chk("busy", 32'(busy[i]), 32'd1);
                    if (m_pos[i] == flen - 1) begin
                        m_act[i]     = 1'b0;
                        frame_cnt[i]++;
                        last_done[i] = cyc;
                        if (i == 0) begin
                            sent_q.push_back(inflight[i]);
                            dn_log.push_back(cyc);
                        end
                    end else begin
                        m_pos[i]++;
                    end
                end
            end
        end
    end

    task automatic push(input int i, input logic [7:0] v);
        @(negedge clk);
        push_vld[i] = 1'b1;
        push_dat[i] = v;
        @(negedge clk);
        push_vld[i] = 1'b0;
        push_cnt[i]++;
    endtask

    task automatic wait_frames(input int i, input int n, input int budget);
        for (int k = 0; k < budget && frame_cnt[i] < n; k++) @(negedge clk);
        chk("frames_seen", 32'(frame_cnt[i]), 32'(n));
    endtask

    task automatic wait_bitpos(input int pos, input int budget);
        for (int k = 0; k < budget && !(m_act[0] && m_pos[0] >= pos); k++) @(negedge clk);
        chk("reach_pos", 32'(m_act[0] && m_pos[0] >= pos), 32'd1);
    endtask

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int         t0;
        int         base;
        int         pbase;
        int         base1;
        logic [7:0] r1;
        logic [7:0] r2;

        reset       = 2'b11;
        enable      = 2'b00;
        push_vld    = 2'b00;
        push_dat[0] = '0;
        push_dat[1] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_tx", 32'(tx[i]), 32'd1);
            chk("rst_busy", 32'(busy[i]), 32'd0);
            chk("rst_read", 32'(fifo_read[i]), 32'd0);
            chk("rst_done", 32'(frame_done[i]), 32'd0);
        end
        reset = 2'b00;
        repeat (2) @(negedge clk);

        // Basic frame 0xA5, 4 clk/bit.
        push(0, 8'hA5);
        @(negedge clk);
        enable[0] = 1'b1;
        t0        = cyc;
        wait_frames(0, 1, 200);
        chk("lat_basic", 32'(last_start[0] - t0), 32'd2);
        chk("len_basic", 32'(last_done[0] - last_start[0] + 1), 32'd40);
        chk("pops_basic", 32'(pop_cnt[0]), 32'd1);
        chk("byte_basic", 32'(sent_q[0]), 32'hA5);
        @(negedge clk);
        chk("busy_after", 32'(busy[0]), 32'd0);

        // Write into an empty FIFO while idle and enabled: the fresh word, not stale RAM, goes out.
        @(negedge clk);
        push_vld[0] = 1'b1;
        push_dat[0] = 8'h3C;
        t0          = cyc;
        @(negedge clk);
        push_vld[0] = 1'b0;
        push_cnt[0]++;
        wait_frames(0, 2, 200);
        chk("lat_race", 32'(last_start[0] - t0), 32'd3);
        chk("byte_race", 32'(sent_q[1]), 32'h3C);

        // Burst of three preloaded words.
        enable[0] = 1'b0;
        push(0, 8'h00);
        push(0, 8'hFF);
        push(0, 8'h55);
        base  = frame_cnt[0];
        pbase = pop_cnt[0];
        @(negedge clk);
        enable[0] = 1'b1;
        wait_frames(0, base + 3, 600);
        if (st_log.size() >= base + 3 && dn_log.size() >= base + 3) begin
            chk("gap1", 32'(st_log[base+1] - dn_log[base]), 32'd3);
            chk("gap2", 32'(st_log[base+2] - dn_log[base+1]), 32'd3);
            chk("burst_b0", 32'(sent_q[base]), 32'h00);
            chk("burst_b1", 32'(sent_q[base+1]), 32'hFF);
            chk("burst_b2", 32'(sent_q[base+2]), 32'h55);
        end
        chk("pops_burst", 32'(pop_cnt[0] - pbase), 32'd3);
        chk("empty_burst", 32'(fifo_empty[0]), 32'd1);
        repeat (20) @(negedge clk);
        chk("no_4th_pop", 32'(pop_cnt[0] - pbase), 32'd3);

        // Drop enable mid-DATA with two words queued.
        enable[0] = 1'b0;
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        push(0, r1);
        push(0, r2);
        base  = frame_cnt[0];
        pbase = pop_cnt[0];
        @(negedge clk);
        enable[0] = 1'b1;
        wait_bitpos(8, 100);
        enable[0] = 1'b0;
        wait_frames(0, base + 1, 200);
        repeat (30) @(negedge clk);
        chk("pops_gated", 32'(pop_cnt[0] - pbase), 32'd1);
        chk("busy_gated", 32'(busy[0]), 32'd0);
        chk("frames_gated", 32'(frame_cnt[0]), 32'(base + 1));
        @(negedge clk);
        enable[0] = 1'b1;
        t0        = cyc;
        wait_frames(0, base + 2, 200);
        chk("lat_reenable", 32'(last_start[0] - t0), 32'd2);
        chk("byte_reenable", 32'(sent_q[sent_q.size()-1]), 32'(r2));

        // Async reset during data bit 3; the popped word is dropped, the next one goes out intact.
        enable[0] = 1'b0;
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        push(0, r1);
        push(0, r2);
        base  = frame_cnt[0];
        pbase = pop_cnt[0];
        @(negedge clk);
        enable[0] = 1'b1;
        wait_bitpos(17, 100);
        #2 reset[0] = 1'b1;
        #1;
        chk("arst_tx", 32'(tx[0]), 32'd1);
        chk("arst_busy", 32'(busy[0]), 32'd0);
        chk("arst_read", 32'(fifo_read[0]), 32'd0);
        repeat (2) @(negedge clk);
        reset[0] = 1'b0;
        wait_frames(0, base + 1, 300);
        chk("arst_byte", 32'(sent_q[sent_q.size()-1]), 32'(r2));
        chk("arst_pops", 32'(pop_cnt[0] - pbase), 32'd2);

        // Two stop bits at 2 clk/bit: 0x81.
        push(1, 8'h81);
        @(negedge clk);
        enable[1] = 1'b1;
        t0        = cyc;
        wait_frames(1, 1, 200);
        chk("lat_sb2", 32'(last_start[1] - t0), 32'd2);
        chk("len_sb2", 32'(last_done[1] - last_start[1] + 1), 32'd22);

        // Random words with random enable toggling on both instances.
        base  = frame_cnt[0];
        base1 = frame_cnt[1];
        for (int k = 0; k < 16; k++) begin
            push(0, 8'($urandom));
            if (k % 2 == 0) push(1, 8'($urandom));
            enable[0] = ($urandom_range(0, 3) != 0);
            enable[1] = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(0, 25)) @(negedge clk);
        end
        enable = 2'b11;
        wait_frames(0, base + 16, 1200);
        wait_frames(1, base1 + 8, 600);
        chk("rand_pops0", 32'(pop_cnt[0]), 32'(push_cnt[0]));
        chk("rand_pops1", 32'(pop_cnt[1]), 32'(push_cnt[1]));
        repeat (5) @(negedge clk);
        chk("rand_idle0", 32'(busy[0]), 32'd0);
        chk("rand_idle1", 32'(busy[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
